// File: rtl/pc_rstack_pkg.sv
// Shared definitions for the program counter / return-address stack.
// Operation encoding, a constant clog2 helper and the stack-pointer width rule.
package pc_rstack_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_LOAD = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } op_e;

  // Smallest r such that 2**r >= n.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

  // The pointer counts 0..depth inclusive, so it needs one state more than the storage.
  function automatic int sp_width(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_rstack_lifo.sv
// Return-address storage: one synchronous write port, one combinational read port.
// Contents are never reset; the pointer in the parent decides what is valid.
module pc_rstack_lifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pc_rstack.sv
// Program counter with integrated return-address stack and tri-state bus output.
// Optional feature: define PC_RSTACK_REL_EN for PC-relative load/call targets.
module pc_rstack
  import pc_rstack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int SPW  = sp_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_bar,
  inout  wire [WIDTH-1:0]  bus,
  input  logic             en_bar,
  input  logic             load_bar,
  input  logic             inc,
  input  logic             push,
  input  logic             pop,
  input  logic             rel,
  output logic [WIDTH-1:0] value,
  output logic [SPW-1:0]   sp,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam int AW = clog2(DEPTH);

  op_e              op;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] rd_data;
  logic             we;

  assign bus   = en_bar ? {WIDTH{1'bz}} : value;
  assign empty = (sp == '0);
  assign full  = (sp == SPW'(DEPTH));

  // Priority: pop > load/call > inc > hold.
  always_comb begin
    op = OP_HOLD;
    if (pop)            op = OP_RET;
    else if (!load_bar) op = push ? OP_CALL : OP_LOAD;
    else if (inc)       op = OP_INC;
  end

`ifdef PC_RSTACK_REL_EN
  assign target = rel ? (value + bus) : bus;
`else
  logic unused_rel;
  assign unused_rel = rel;
  assign target     = bus;
`endif

  assign we = (op == OP_CALL) && !full;

  pc_rstack_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_lifo (
    .clk     (clk),
    .we      (we),
    .wr_addr (AW'(sp)),
    .wr_data (value),
    .rd_addr (AW'(sp - SPW'(1))),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      value <= '0;
      sp    <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      case (op)
        OP_RET: begin
          if (empty) begin
            unf <= 1'b1;
          end else begin
            value <= rd_data;
            sp    <= sp - SPW'(1);
          end
        end
        OP_LOAD: value <= target;
        OP_CALL: begin
          // A refused push still jumps; only the return address is lost.
          value <= target;
          if (full) ovf <= 1'b1;
          else      sp  <= sp + SPW'(1);
        end
        OP_INC:  value <= value + WIDTH'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_rstack.sv
// Bench for pc_rstack (WIDTH=16, DEPTH=4): directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_pc_rstack;

  localparam int W = 16;
  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_bar = 1'b0;
  always #5 clk = ~clk;

  logic         en_bar, load_bar, inc, push, pop, rel;
  logic         tb_drive;
  logic [W-1:0] tb_bus;
  wire  [W-1:0] bus;
  logic [W-1:0] value;
  logic [2:0]   sp;
  logic         empty, full, ovf, unf;

  assign bus = tb_drive ? tb_bus : {W{1'bz}};

  pc_rstack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset_bar (reset_bar),
    .bus       (bus),
    .en_bar    (en_bar),
    .load_bar  (load_bar),
    .inc       (inc),
    .push      (push),
    .pop       (pop),
    .rel       (rel),
    .value     (value),
    .sp        (sp),
    .empty     (empty),
    .full      (full),
    .ovf       (ovf),
    .unf       (unf)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_val;
  logic [W-1:0] m_stk[$];
  logic         m_ovf, m_unf;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_val = '0;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One clock of architectural behaviour, from the operation rules.
  task automatic model_update();
    logic [W-1:0] seen;
    logic [W-1:0] tgt;
    seen = en_bar ? tb_bus : m_val;
    tgt  = seen;
`ifdef PC_RSTACK_REL_EN
    if (rel) tgt = m_val + seen;
`endif
    if (pop) begin
      if (m_stk.size() == 0) m_unf = 1'b1;
      else m_val = m_stk.pop_back();
    end else if (!load_bar) begin
      if (push) begin
        if (m_stk.size() == D) m_ovf = 1'b1;
        else m_stk.push_back(m_val);
      end
      m_val = tgt;
    end else if (inc) begin
      m_val = m_val + 1;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".value"}, 32'(value), 32'(m_val));
    check_eq({tag, ".sp"},    32'(sp),    32'(m_stk.size()));
    check_eq({tag, ".empty"}, 32'(empty), 32'(m_stk.size() == 0));
    check_eq({tag, ".full"},  32'(full),  32'(m_stk.size() == D));
    check_eq({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
    check_eq({tag, ".unf"},   32'(unf),   32'(m_unf));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic p, input logic lb, input logic pu,
                       input logic in, input logic rl, input logic [W-1:0] bv);
    pop = p; load_bar = lb; push = pu; inc = in; rel = rl;
    en_bar = 1'b1; tb_drive = 1'b1; tb_bus = bv;
  endtask

  task automatic step(input string tag);
    model_update();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] rel_exp;
    idle();
    model_reset();
    #12;
    check_all("reset");
    reset_bar = 1'b1;
    @(posedge clk); #1;

    // increment and wrap
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
      step("inc");
    end
    check_eq("inc3_const", 32'(value), 32'h0003);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF); step("load_ffff");
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000); step("wrap");
    check_eq("wrap_const", 32'(value), 32'h0000);

    // call then return
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0100); step("load_0100");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h2000); step("call");
    check_eq("call_const", 32'(value), 32'h2000);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000); step("ret");
    check_eq("ret_const", 32'(value), 32'h0100);

    // five nested calls, fifth overflows
    exp_q.delete();
    exp_q.push_back(16'h0100);
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, W'(16'h1000 * k + k));
      if (k <= 3) exp_q.push_back(W'(16'h1000 * k + k));
      step("nest_call");
    end
    check_eq("nest_ovf", 32'(ovf), 32'd1);
    check_eq("nest_val", 32'(value), 32'h5005);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      step("nest_ret");
      check_eq("nest_lifo", 32'(value), 32'(exp_q.pop_back()));
    end

    // pop at empty with inc, then pop beats load
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000); step("pop_empty");
    check_eq("unf_const", 32'(unf), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h3000); step("c1");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h4000); step("c2");
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'hBEEF); step("pop_vs_load");
    check_eq("pop_wins", 32'(value), 32'h3000);

    // relative load
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1000); step("load_1000");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFF0); step("rel_load");
`ifdef PC_RSTACK_REL_EN
    rel_exp = 16'h0FF0;
`else
    rel_exp = 16'hFFF0;
`endif
    check_eq("rel_const", 32'(value), 32'(rel_exp));

    // bus behaviour
    idle();
    tb_bus = 16'hA5A5;
    #1;
    check_eq("bus_hiz", 32'(bus), 32'hA5A5);
    tb_drive = 1'b0; en_bar = 1'b0;
    #1;
    check_eq("bus_drive", 32'(bus), 32'(value));
    load_bar = 1'b0;
    step("self_load");

    // reset in the middle of a call at sp 3
    reset_bar = 1'b0; #1; reset_bar = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, W'($urandom_range(0, 16'hFFFF)));
      step("pre_rst_call");
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7777);
    #2;
    reset_bar = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    check_eq("async_rst_val", 32'(value), 32'h0000);
    idle();
    #2;
    reset_bar = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000); step("post_rst_inc");

    // random traffic
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) > 3),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            W'($urandom_range(0, 16'hFFFF)));
      if ($urandom_range(0, 9) == 0) begin
        en_bar = 1'b0; tb_drive = 1'b0;
      end
      step("rand");
      if ($urandom_range(0, 149) == 0) begin
        reset_bar = 1'b0; #2; reset_bar = 1'b1;
        model_reset();
        check_all("rand_rst");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_rstack.md
# pc_rstack

Parametrised program counter with an integrated return-address stack, replacing the fixed 16-bit counter in the CPU datapath. Holds the current instruction address, increments, loads absolute targets from the bus, and performs single-cycle call (push + load) and return (pop) operations. Drives its value onto the shared bus through a tri-state output, exactly as the existing counter does, so the control-word decoder needs only the added push/pop/rel lines.

## Interface
- WIDTH, 16: address/bus width in bits (≥4)
- DEPTH, 8: return-stack entries (≥2, power of two not required)
- clk  in  1  rising-edge clock
- reset_bar  in  1  asynchronous active-low reset
- bus  inout  WIDTH  shared data bus; load source; driven with value when en_bar low
- en_bar  in  1  active-low bus output enable
- load_bar  in  1  active-low load from bus
- inc  in  1  increment enable
- push  in  1  with load_bar low: call (save value, then load)
- pop  in  1  return: value <= stack top
- rel  in  1  with load_bar low: relative load (see Configuration)
- value  out  WIDTH  current PC, registered
- sp  out  clog2(DEPTH+1)  stack occupancy, 0..DEPTH
- empty  out  1  sp == 0
- full  out  1  sp == DEPTH
- ovf  out  1  sticky: push attempted while full
- unf  out  1  sticky: pop attempted while empty

## Operation
- Operation per rising edge, priority: pop > load (call if push) > inc > hold.
- pop, not empty: value <= stack[sp-1]; sp--.
- pop, empty: value, sp unchanged; unf <= 1.
- load_bar low, push low: value <= target.
- load_bar low, push high, not full: stack[sp] <= value; sp++; value <= target.
- load_bar low, push high, full: push refused (stack, sp unchanged); value <= target; ovf <= 1.
- push high with load_bar high: ignored, no flag.
- inc high, no pop/load: value <= value + 1 mod 2^WIDTH; all-ones wraps to 0, no flag.
- pop with load_bar low or inc high: pop wins; load, push, inc ignored this cycle.
- target = bus, or value + bus per Configuration.
- ovf/unf clear only on reset.
- Bus: en_bar low drives value onto bus combinationally; en_bar high leaves bus high-Z. en_bar low and load_bar low together loads value onto itself (legal, equals hold).

## Timing
- Reset (reset_bar low, asynchronous, no clock needed): value = 0, sp = 0, empty = 1, full = 0, ovf = 0, unf = 0. Stack storage not cleared; contents undefined and unreadable while sp = 0.
- Reset deasserted mid-call/return: no partial update; first edge after release acts normally.
- value, sp, flags update one cycle after the controlling edge; empty/full are combinational decodes of registered sp.
- Bus sampled at the same edge that performs load; setup per clk.
- Call followed immediately by return restores the pre-call value in two cycles total.

## Configuration
- PC_RSTACK_REL_EN defined: rel high with load_bar low gives target = value + bus, two's-complement, mod 2^WIDTH; applies to both plain load and call.
- Not defined: rel ignored; target always = bus; no adder instantiated.

## Structure
- Package pc_rstack_pkg: op encoding (OP_HOLD, OP_INC, OP_LOAD, OP_CALL, OP_RET), clog2 function, sp width derivation.
- Sub-module pc_rstack_lifo: DEPTH×WIDTH storage with write-at-sp / read-at-sp-1 ports; pointer and flags in the top level.

## Test plan (WIDTH=16, DEPTH=4)
- Reset, inc ×3 from 0 -> value 0x0003; load_bar low with bus 0xFFFF, then inc -> value 0x0000, no flag.
- value 0x0100, call to 0x2000 -> value 0x2000, sp 1; pop -> value 0x0100, sp 0, empty 1.
- Five nested calls -> sp 4, full 1, ovf 1 on fifth, value = fifth target; four pops return addresses in LIFO order.
- Pop at sp 0 with inc high -> value unchanged, unf 1; pop with load_bar low at sp 2 -> pop taken, load ignored.
- PC_RSTACK_REL_EN, value 0x1000, rel with bus 0xFFF0 -> value 0x0FF0; without macro -> value 0xFFF0.
- en_bar high -> bus Z; reset_bar low mid-call at sp 3 -> value 0, sp 0, flags 0 immediately, no clock.
